// File: rtl/img_rsz_comp_eng_pipe.sv
// Resize compute engine: accumulates block size, then divides per-channel block sums with an iterative restoring divider.
// Optional build macro IMG_RSZ_ROUND_EN enables round-half-up division (one extra divider iteration).
`timescale 1ns/1ps
module img_rsz_comp_eng_pipe #(
    parameter int CHN_NUM   = 3,
    parameter int PXL_W     = 8,
    parameter int BLK_HOR_W = 5,
    parameter int BLK_VER_W = 5,
    parameter int SUM_W     = 18,
    parameter int X_W       = 10,
    parameter int Y_W       = 10
) (
    input  logic                           Clk,
    input  logic                           ResetN,
    input  logic                           CfgVld,
    input  logic [BLK_HOR_W-1:0]           BlkSzHor,
    input  logic [BLK_VER_W-1:0]           BlkSzVer,
    input  logic [CHN_NUM*SUM_W-1:0]       CompBlkData,
    input  logic [X_W-1:0]                 CompBlkXMsk,
    input  logic [Y_W-1:0]                 CompBlkYMsk,
    input  logic                           CompBlkVld,
    output logic                           CompBlkRdy,
    output logic [CHN_NUM*PXL_W-1:0]       CeRszPxlData,
    output logic [X_W-1:0]                 CeRszPxlXMsk,
    output logic [Y_W-1:0]                 CeRszPxlYMsk,
    output logic                           CeCompVld,
    input  logic                           CeCompRdy,
    output logic [BLK_HOR_W+BLK_VER_W-1:0] ProcBlkSz,
    output logic                           CompEngRdy,
    output logic                           CfgErr,
    input  logic                           RszImgComp
);

    localparam int PS_W  = BLK_HOR_W + BLK_VER_W;
    localparam int REM_W = PS_W + 1;
`ifdef IMG_RSZ_ROUND_EN
    localparam int DIV_W = SUM_W + 1;
`else
    localparam int DIV_W = SUM_W;
`endif
    localparam int CNT_W = $clog2(DIV_W + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ACC   = 3'd1;
    localparam logic [2:0] ST_READY = 3'd2;
    localparam logic [2:0] ST_DIV   = 3'd3;
    localparam logic [2:0] ST_OUT   = 3'd4;

    logic [2:0]           stateR;
    logic [BLK_HOR_W-1:0] horR;
    logic [BLK_VER_W-1:0] verR;
    logic [BLK_VER_W-1:0] accCntR;
    logic [CNT_W-1:0]     divCntR;
    logic                 rszPendR;
    logic [REM_W-1:0]     remR     [CHN_NUM];
    logic [DIV_W-1:0]     quoR     [CHN_NUM];
    logic [REM_W-1:0]     remNxtS  [CHN_NUM];
    logic [DIV_W-1:0]     quoNxtS  [CHN_NUM];
    logic [DIV_W-1:0]     dividendS[CHN_NUM];

    // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
    function automatic logic [REM_W+DIV_W-1:0] divStep(
        input logic [REM_W-1:0] rem,
        input logic [DIV_W-1:0] quo,
        input logic [PS_W-1:0]  dsr
    );
        logic [REM_W-1:0] trial;
        logic [REM_W-1:0] remN;
        logic [DIV_W-1:0] quoN;
        trial = {rem[REM_W-2:0], quo[DIV_W-1]};
        if (trial >= {1'b0, dsr}) begin
            remN = trial - {1'b0, dsr};
            quoN = {quo[DIV_W-2:0], 1'b1};
        end else begin
            remN = trial;
            quoN = {quo[DIV_W-2:0], 1'b0};
        end
        return {remN, quoN};
    endfunction

    function automatic logic [PXL_W-1:0] satPxl(input logic [DIV_W-1:0] q);
        if (q > DIV_W'({PXL_W{1'b1}})) begin
            return {PXL_W{1'b1}};
        end else begin
            return q[PXL_W-1:0];
        end
    endfunction

    // Ready flags decode straight from state; RszImgComp gates block acceptance.
    assign CompBlkRdy = (stateR == ST_READY) && !RszImgComp;
    assign CompEngRdy = (stateR == ST_READY) || (stateR == ST_DIV) || (stateR == ST_OUT);

    // Per-channel dividend preparation and next divider step.
    always_comb begin
        for (int c = 0; c < CHN_NUM; c++) begin
`ifdef IMG_RSZ_ROUND_EN
            dividendS[c] = DIV_W'(CompBlkData[c*SUM_W +: SUM_W]) + DIV_W'(ProcBlkSz >> 1);
`else
            dividendS[c] = CompBlkData[c*SUM_W +: SUM_W];
`endif
            {remNxtS[c], quoNxtS[c]} = divStep(remR[c], quoR[c], ProcBlkSz);
        end
    end

    // Control FSM, block-size accumulator, divider state and registered outputs.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            stateR       <= ST_IDLE;
            horR         <= '0;
            verR         <= '0;
            accCntR      <= '0;
            divCntR      <= '0;
            rszPendR     <= 1'b0;
            ProcBlkSz    <= '0;
            CfgErr       <= 1'b0;
            CeCompVld    <= 1'b0;
            CeRszPxlData <= '0;
            CeRszPxlXMsk <= '0;
            CeRszPxlYMsk <= '0;
            for (int c = 0; c < CHN_NUM; c++) begin
                remR[c] <= '0;
                quoR[c] <= '0;
            end
        end else begin
            case (stateR)
                ST_IDLE: begin
                    if (CfgVld) begin
                        horR      <= BlkSzHor;
                        verR      <= BlkSzVer;
                        ProcBlkSz <= '0;
                        accCntR   <= '0;
                        // A zero dimension would make the divisor zero, so the engine never leaves IDLE.
                        if ((BlkSzHor == '0) || (BlkSzVer == '0)) begin
                            CfgErr <= 1'b1;
                        end else begin
                            CfgErr <= 1'b0;
                            stateR <= ST_ACC;
                        end
                    end
                end
                ST_ACC: begin
                    ProcBlkSz <= ProcBlkSz + PS_W'(horR);
                    if (accCntR == (verR - BLK_VER_W'(1))) begin
                        stateR <= ST_READY;
                    end else begin
                        accCntR <= accCntR + BLK_VER_W'(1);
                    end
                end
                ST_READY: begin
                    if (RszImgComp) begin
                        stateR <= ST_IDLE;
                    end else if (CompBlkVld) begin
                        for (int c = 0; c < CHN_NUM; c++) begin
                            remR[c] <= '0;
                            quoR[c] <= dividendS[c];
                        end
                        CeRszPxlXMsk <= CompBlkXMsk;
                        CeRszPxlYMsk <= CompBlkYMsk;
                        divCntR      <= '0;
                        stateR       <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    for (int c = 0; c < CHN_NUM; c++) begin
                        remR[c] <= remNxtS[c];
                        quoR[c] <= quoNxtS[c];
                    end
                    divCntR <= divCntR + CNT_W'(1);
                    if (RszImgComp) begin
                        rszPendR <= 1'b1;
                    end
                    // Final step result goes straight to the output register.
                    if (divCntR == CNT_W'(DIV_W - 1)) begin
                        for (int c = 0; c < CHN_NUM; c++) begin
                            CeRszPxlData[c*PXL_W +: PXL_W] <= satPxl(quoNxtS[c]);
                        end
                        CeCompVld <= 1'b1;
                        stateR    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (CeCompRdy) begin
                        CeCompVld <= 1'b0;
                        rszPendR  <= 1'b0;
                        stateR    <= (rszPendR || RszImgComp) ? ST_IDLE : ST_READY;
                    end else if (RszImgComp) begin
                        rszPendR <= 1'b1;
                    end
                end
                default: begin
                    stateR    <= ST_IDLE;
                    CeCompVld <= 1'b0;
                    rszPendR  <= 1'b0;
                end
            endcase
        end
    end

endmodule
